// File: rtl/pong_pkg.sv
// Shared definitions for the pong input front end: quadrature transition codes,
// default conditioning parameters and the x4 transition classifier.
package pong_pkg;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DB_COUNT    = 4;

    typedef enum logic [1:0] {
        QUAD_NONE = 2'b00,
        QUAD_UP   = 2'b01,
        QUAD_DN   = 2'b10,
        QUAD_ERR  = 2'b11
    } quad_t;

    // Classify a move of the stable {a,b} pair. Forward order is 00,10,11,01.
    function automatic quad_t quad_decode(input logic [1:0] prev, input logic [1:0] curr);
        quad_t res;
        // NOTE: res gets a value before the case so that no path leaves it unassigned.
        res = QUAD_NONE;
        if ((prev ^ curr) == 2'b11) begin
            res = QUAD_ERR;
        end else begin
            case ({prev, curr})
                4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: res = QUAD_UP;
                4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: res = QUAD_DN;
                default:                                res = QUAD_NONE;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/input_debounce.sv
// Synchroniser plus counter debouncer for one asynchronous input pin.
module input_debounce
    import pong_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DB_COUNT    = DEF_DB_COUNT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic raw,
    output logic stable
);

    localparam int               CNT_W    = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   synced;

    // Move the raw pin into the clock domain; keeps running while the project is idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignment so every flop samples its neighbour's old value.
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // Adopt a new level only after it has differed from the stable one for DB_COUNT cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (!enable) begin
            cnt <= '0;
        end else if (synced == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= synced;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/quad_input_bank.sv
// Player input front end: conditions NUM_ENC quadrature encoders and a start
// button, producing step pulses, saturating positions and a button edge pulse.
module quad_input_bank
    import pong_pkg::*;
#(
    parameter int NUM_ENC     = 2,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DB_COUNT    = DEF_DB_COUNT,
    parameter int POS_WIDTH   = 8,
    parameter int POS_MAX     = 255
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           active,
    input  logic                           clear_pos,
    input  logic [NUM_ENC-1:0]             enc_a,
    input  logic [NUM_ENC-1:0]             enc_b,
    input  logic                           btn,
    output logic [NUM_ENC-1:0]             step_up,
    output logic [NUM_ENC-1:0]             step_dn,
    output logic [NUM_ENC-1:0]             enc_err,
    output logic [NUM_ENC*POS_WIDTH-1:0]   pos,
    output logic                           btn_level,
    output logic                           btn_pulse
);

    localparam logic [POS_WIDTH-1:0] POS_TOP = POS_WIDTH'(POS_MAX);

    logic [NUM_ENC-1:0]   stab_a;
    logic [NUM_ENC-1:0]   stab_b;
    logic                 stab_btn;
    logic [1:0]           ab_now [NUM_ENC];
    logic [1:0]           ab_q   [NUM_ENC];
    logic [NUM_ENC-1:0]   primed;
    logic [POS_WIDTH-1:0] pos_q  [NUM_ENC];
    logic                 btn_q;

    for (genvar g = 0; g < NUM_ENC; g++) begin : g_chan
        input_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_COUNT    (DB_COUNT)
        ) u_db_a (
            .clk     (clk),
            .reset_n (reset_n),
            .enable  (active),
            .raw     (enc_a[g]),
            .stable  (stab_a[g])
        );

        input_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_COUNT    (DB_COUNT)
        ) u_db_b (
            .clk     (clk),
            .reset_n (reset_n),
            .enable  (active),
            .raw     (enc_b[g]),
            .stable  (stab_b[g])
        );

        assign ab_now[g] = {stab_a[g], stab_b[g]};
        assign pos[g*POS_WIDTH +: POS_WIDTH] = pos_q[g];
    end

    input_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_COUNT    (DB_COUNT)
    ) u_db_btn (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (active),
        .raw     (btn),
        .stable  (stab_btn)
    );

    assign btn_level = stab_btn;

    // Decode stable pair changes into steps, absorbing the first change after reset or wake-up.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            primed  <= '0;
            step_up <= '0;
            step_dn <= '0;
            enc_err <= '0;
            // NOTE: the position array is only NUM_ENC registers, so it is reset like any other state.
            for (int i = 0; i < NUM_ENC; i++) begin
                ab_q[i]  <= '0;
                pos_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENC; i++) begin
                ab_q[i]    <= ab_now[i];
                step_up[i] <= 1'b0;
                step_dn[i] <= 1'b0;
                enc_err[i] <= 1'b0;
                if (!active) begin
                    primed[i] <= 1'b0;
                end else begin
                    if (ab_now[i] != ab_q[i]) begin
                        if (!primed[i]) begin
                            primed[i] <= 1'b1;
                        end else begin
                            case (quad_decode(ab_q[i], ab_now[i]))
                                QUAD_UP: begin
                                    step_up[i] <= 1'b1;
                                    if (pos_q[i] < POS_TOP) pos_q[i] <= pos_q[i] + POS_WIDTH'(1);
                                end
                                QUAD_DN: begin
                                    step_dn[i] <= 1'b1;
                                    if (pos_q[i] != '0) pos_q[i] <= pos_q[i] - POS_WIDTH'(1);
                                end
                                QUAD_ERR: enc_err[i] <= 1'b1;
                                default:  ;
                            endcase
                        end
                    end
                    // Clear is written last so it overrides a step landing on the same edge.
                    if (clear_pos) pos_q[i] <= '0;
                end
            end
        end
    end

    // Register the button edge pulse one cycle after the stable level rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_q     <= 1'b0;
            btn_pulse <= 1'b0;
        end else begin
            btn_q     <= stab_btn;
            btn_pulse <= active & stab_btn & ~btn_q;
        end
    end

endmodule

// File: tb/tb_quad_input_bank.sv
// Scoreboard bench for quad_input_bank: stimulus tasks predict events from the
// encoder rules and queue them; a monitor pops and compares every output pulse.
module tb_quad_input_bank;

    localparam int NUM_ENC = 2;
    localparam int SYNC    = 2;
    localparam int DB      = 4;
    localparam int PW      = 4;
    localparam int PMAX    = 6;
    localparam int LAT     = SYNC + DB;

    typedef enum int {EV_UP = 0, EV_DN = 1, EV_ERR = 2, EV_BTN = 3} ev_kind_t;
    typedef struct {
        int       edge_no;
        ev_kind_t kind;
        int       ch;
        int       pos;
    } ev_t;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    active = 1'b1;
    logic                    clear_pos = 1'b0;
    logic [NUM_ENC-1:0]      enc_a = '0;
    logic [NUM_ENC-1:0]      enc_b = '0;
    logic                    btn = 1'b0;
    logic [NUM_ENC-1:0]      step_up, step_dn, enc_err;
    logic [NUM_ENC*PW-1:0]   pos;
    logic                    btn_level, btn_pulse;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  edge_cnt = 0;
    ev_t exp_q[$];

    // Reference model state
    bit m_active = 1'b1;
    bit m_pin_a[NUM_ENC], m_pin_b[NUM_ENC], m_st_a[NUM_ENC], m_st_b[NUM_ENC];
    bit m_primed[NUM_ENC];
    int m_pos[NUM_ENC];
    bit m_pin_btn = 1'b0, m_st_btn = 1'b0;

    quad_input_bank #(
        .NUM_ENC(NUM_ENC), .SYNC_STAGES(SYNC), .DB_COUNT(DB), .POS_WIDTH(PW), .POS_MAX(PMAX)
    ) dut (
        .clk(clk), .reset_n(reset_n), .active(active), .clear_pos(clear_pos),
        .enc_a(enc_a), .enc_b(enc_b), .btn(btn),
        .step_up(step_up), .step_dn(step_dn), .enc_err(enc_err), .pos(pos),
        .btn_level(btn_level), .btn_pulse(btn_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(string name, int actual, int expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edge_cnt);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    // Position of a pair in the forward cycle 00,10,11,01
    function automatic int gray_idx(bit a, bit b);
        return a ? (b ? 2 : 1) : (b ? 3 : 0);
    endfunction
    function automatic bit gray_a(int idx);
        return (idx == 1) || (idx == 2);
    endfunction
    function automatic bit gray_b(int idx);
        return (idx == 2) || (idx == 3);
    endfunction

    // A stable change of channel ch to {na,nb} whose registered outputs appear at edge ev_edge.
    task automatic model_stable_enc(int ch, bit na, bit nb, int ev_edge, bit clr);
        int  d;
        ev_t e;
        if (na == m_st_a[ch] && nb == m_st_b[ch]) return;
        d = (gray_idx(na, nb) - gray_idx(m_st_a[ch], m_st_b[ch]) + 4) % 4;
        m_st_a[ch] = na;
        m_st_b[ch] = nb;
        if (!m_primed[ch]) begin
            m_primed[ch] = 1'b1;
            return;
        end
        e.edge_no = ev_edge;
        e.ch      = ch;
        if (d == 1) begin
            e.kind = EV_UP;
            if (m_pos[ch] < PMAX) m_pos[ch]++;
        end else if (d == 3) begin
            e.kind = EV_DN;
            if (m_pos[ch] > 0) m_pos[ch]--;
        end else begin
            e.kind = EV_ERR;
        end
        if (clr) foreach (m_pos[i]) m_pos[i] = 0;
        e.pos = m_pos[ch];
        exp_q.push_back(e);
    endtask

    task automatic btn_stable(bit v, int ev_edge);
        ev_t e;
        if (v == m_st_btn) return;
        m_st_btn = v;
        if (v) begin
            e.edge_no = ev_edge; e.kind = EV_BTN; e.ch = 0; e.pos = 0;
            exp_q.push_back(e);
        end
    endtask

    task automatic enc_drive(int ch, bit a, bit b, bit modeled);
        enc_a[ch] = a;
        enc_b[ch] = b;
        m_pin_a[ch] = a;
        m_pin_b[ch] = b;
        if (modeled && m_active) model_stable_enc(ch, a, b, edge_cnt + 1 + LAT, 1'b0);
    endtask

    task automatic enc_set(int ch, bit a, bit b);
        enc_drive(ch, a, b, 1'b1);
    endtask

    task automatic enc_set_clear(int ch, bit a, bit b);
        enc_a[ch] = a; enc_b[ch] = b;
        m_pin_a[ch] = a; m_pin_b[ch] = b;
        model_stable_enc(ch, a, b, edge_cnt + 1 + LAT, 1'b1);
        tick(LAT);
        clear_pos = 1'b1;
        tick(1);
        clear_pos = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_pos = 1'b1;
        tick(1);
        clear_pos = 1'b0;
        foreach (m_pos[i]) m_pos[i] = 0;
    endtask

    task automatic glitch(int ch, bit on_a, int len);
        bit oa, ob;
        oa = m_pin_a[ch];
        ob = m_pin_b[ch];
        enc_drive(ch, on_a ? ~oa : oa, on_a ? ob : ~ob, len >= DB);
        tick(len);
        enc_drive(ch, oa, ob, len >= DB);
    endtask

    task automatic btn_set(bit v);
        btn = v;
        m_pin_btn = v;
        if (m_active) btn_stable(v, edge_cnt + 1 + LAT);
    endtask

    task automatic set_active(bit v);
        int j;
        active = v;
        j = edge_cnt + 1;
        m_active = v;
        if (!v) begin
            foreach (m_primed[i]) m_primed[i] = 1'b0;
        end else begin
            // Pins that moved while idle settle DB_COUNT edges after wake-up.
            for (int ch = 0; ch < NUM_ENC; ch++)
                model_stable_enc(ch, m_pin_a[ch], m_pin_b[ch], j + DB, 1'b0);
            btn_stable(m_pin_btn, j + DB);
        end
    endtask

    task automatic model_release();
        int k;
        k = edge_cnt + 1;
        if (m_active) begin
            for (int ch = 0; ch < NUM_ENC; ch++)
                model_stable_enc(ch, m_pin_a[ch], m_pin_b[ch], k + LAT, 1'b0);
            btn_stable(m_pin_btn, k + LAT);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        foreach (m_pos[i]) begin
            m_pos[i] = 0; m_primed[i] = 1'b0; m_st_a[i] = 1'b0; m_st_b[i] = 1'b0;
        end
        m_st_btn = 1'b0;
        tick(3);
        check("reset_pos", int'(pos), 0);
        check("reset_btn_level", int'(btn_level), 0);
        check("reset_pulses", int'({step_up, step_dn, enc_err, btn_pulse}), 0);
        reset_n = 1'b1;
        model_release();
    endtask

    task automatic check_state(string tag);
        for (int ch = 0; ch < NUM_ENC; ch++)
            check({tag, "_pos"}, int'(pos[ch*PW +: PW]), m_pos[ch]);
        check({tag, "_btn_level"}, int'(btn_level), int'(m_st_btn));
    endtask

    task automatic observe(ev_kind_t kind, int ch);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event_kind", int'(kind), -1);
            return;
        end
        e = exp_q.pop_front();
        check("event_edge", edge_cnt, e.edge_no);
        check("event_kind", int'(kind), int'(e.kind));
        check("event_channel", ch, e.ch);
        if (kind != EV_BTN) check("event_pos", int'(pos[ch*PW +: PW]), e.pos);
    endtask

    // Monitor: every output pulse must match the head of the expected-event queue.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int ch = 0; ch < NUM_ENC; ch++) begin
                if (step_up[ch]) observe(EV_UP, ch);
                if (step_dn[ch]) observe(EV_DN, ch);
                if (enc_err[ch]) observe(EV_ERR, ch);
            end
            if (btn_pulse) observe(EV_BTN, 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached with %0d events pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int ch, cur, nxt, r;
        foreach (m_pos[i]) begin
            m_pin_a[i] = 0; m_pin_b[i] = 0; m_st_a[i] = 0; m_st_b[i] = 0;
            m_primed[i] = 0; m_pos[i] = 0;
        end

        // Channel 0 resting at 11 and button held through reset.
        enc_a[0] = 1'b1; enc_b[0] = 1'b1; m_pin_a[0] = 1'b1; m_pin_b[0] = 1'b1;
        btn = 1'b1; m_pin_btn = 1'b1;
        tick(1);
        do_reset();
        tick(20);
        check_state("after_release");

        // 11 -> 01 is a forward step once primed.
        enc_set(0, 1'b0, 1'b1);
        tick(10);
        check_state("first_step");
        btn_set(1'b0);
        tick(10);

        // Prime channel 1, then a full forward cycle and its reverse.
        enc_set(1, 1'b1, 1'b0); tick(10);
        enc_set(1, 1'b0, 1'b0); tick(10);
        for (int s = 1; s <= 4; s++) begin enc_set(1, gray_a(s % 4), gray_b(s % 4)); tick(10); end
        check_state("fwd_cycle");
        for (int s = 3; s >= 0; s--) begin enc_set(1, gray_a(s), gray_b(s)); tick(10); end
        check_state("rev_cycle");

        // Glitch shorter than the debounce window, then one exactly as long.
        glitch(0, 1'b1, 3); tick(12);
        check_state("glitch3");
        glitch(0, 1'b1, 4); tick(12);
        check_state("glitch4");

        // Saturation at the top, then a clear landing on a step edge.
        for (int s = 1; s <= 8; s++) begin enc_set(1, gray_a(s % 4), gray_b(s % 4)); tick(10); end
        check_state("saturated");
        enc_set_clear(1, gray_a(1), gray_b(1));
        tick(10);
        check_state("clear_on_step");
        enc_set(0, 1'b0, 1'b0); tick(10);
        pulse_clear(); tick(4);
        check_state("idle_clear");

        // Illegal double-bit moves on both channels.
        enc_set(0, 1'b1, 1'b1); tick(10);
        enc_set(1, 1'b0, 1'b1); tick(10);
        check_state("illegal");

        // Idle: toggles are ignored, then wake-up with the button held.
        enc_set(0, 1'b0, 1'b1); tick(10);
        set_active(1'b0); tick(5);
        enc_set(0, 1'b1, 1'b1); tick(3);
        enc_set(1, 1'b1, 1'b1); tick(3);
        enc_set(1, 1'b0, 1'b1); tick(3);
        btn_set(1'b1); tick(12);
        check_state("idle");
        set_active(1'b1); tick(20);
        check_state("wake");
        enc_set(0, 1'b0, 1'b1); tick(10);
        enc_set(1, 1'b1, 1'b1); tick(10);
        enc_set(1, 1'b1, 1'b0); tick(10);
        check_state("after_wake");

        // Reset in the middle of play.
        enc_set(0, 1'b0, 1'b0); tick(10);
        do_reset();
        tick(20);
        check_state("mid_reset");
        enc_set(0, 1'b1, 1'b0); tick(10);

        // Randomised play.
        for (int it = 0; it < 60; it++) begin
            r  = $urandom_range(0, 9);
            ch = $urandom_range(0, NUM_ENC - 1);
            cur = gray_idx(m_pin_a[ch], m_pin_b[ch]);
            if (r <= 5) begin
                nxt = (cur + (($urandom_range(0, 1) == 1) ? 1 : 3)) % 4;
                enc_set(ch, gray_a(nxt), gray_b(nxt));
            end else if (r == 6) begin
                nxt = (cur + 2) % 4;
                enc_set(ch, gray_a(nxt), gray_b(nxt));
            end else if (r == 7) begin
                btn_set(~m_pin_btn);
            end else if (r == 8) begin
                pulse_clear();
            end else begin
                glitch(ch, $urandom_range(0, 1) == 1, $urandom_range(1, DB - 1));
            end
            tick($urandom_range(8, 14));
        end
        tick(30);
        check_state("final");
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
